led_activity_stretcher: RTL and testbench
=========================================

Name: led_activity_stretcher

Overview:
- Sits directly upstream of the board LED register stage.
- Converts single-cycle activity pulses from the trading datapath into human-visible LED on-times, one stretcher per LED across 10 green and 10 red channels.
- Optional heartbeat on green channel 9.
- Publishes the combined 20-bit pattern through a valid/ready update port. The LED register stage latches that pattern and drives the pins.

Parameters:
- TICK_DIV, 50000, clk cycles per stretch tick; legal range ≥2.
- HOLD_TICKS, 100, ticks an LED stays lit after its last pulse; legal range ≥1, ≤2^CNT_W−1.
- CNT_W, 8, width of each per-channel hold counter.
- HB_EN, 1, 1 = green channel 9 driven by heartbeat instead of act_g[9].
- HB_TICKS, 250, ticks per heartbeat half-period; legal range ≥1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- act_g  in  10  per-channel green activity pulses, sampled every clk
- act_r  in  10  per-channel red activity pulses, sampled every clk
- upd_valid  out  1  update pattern available
- upd_ready  in  1  downstream accepts update
- upd_ledg  out  10  green pattern for this update
- upd_ledr  out  10  red pattern for this update
- tick_o  out  1  one-cycle stretch tick (debug/observability)

Behaviour:
- Reset: one clock only; reset is synchronous, active-high, sampled on posedge clk.
  - Reset clears the prescaler, all hold counters, the heartbeat counter and phase, last_sent, upd_valid, upd_ledg and upd_ledr.
  - All outputs read 0 the cycle after rst is sampled high.
  - Reset mid-transfer drops the pending update; there is no replay.
- Prescaler:
  - Counts 0..TICK_DIV−1 and wraps.
  - tick is high for exactly one cycle when count==TICK_DIV−1, so the tick period is TICK_DIV cycles.
  - The first tick after reset arrives at cycle TICK_DIV−1.
- Per-channel hold counter (20 instances):
  - If act is high in a cycle, the counter loads HOLD_TICKS, irrespective of tick. Reload wins over a simultaneous decrement.
  - Else, if tick is high and cnt≠0, the counter decrements.
  - It saturates at 0; there is no wrap.
  - A pulse that arrives while the LED is already lit restarts the full hold.
- Live pattern: live bit = (cnt≠0), combinational from the registered counters.
  - A pulse at cycle N makes the live bit high at N+1.
  - On-time after the last pulse is between HOLD_TICKS−1 and HOLD_TICKS tick periods, depending on prescaler phase.
- Heartbeat (HB_EN=1):
  - A separate counter counts ticks 0..HB_TICKS−1.
  - The phase bit toggles on the tick that wraps the counter.
  - live_g[9] = phase; act_g[9] is ignored.
- Update handshake:
  - State is held in the last_sent register.
  - When upd_valid==0 and live≠last_sent: register upd_ledg/upd_ledr←live and upd_valid←1. A pulse at N therefore gives upd_valid high at N+2.
  - While upd_valid && !upd_ready: upd_ledg/upd_ledr and upd_valid stay stable. Live changes in this window are not merged into the pending update.
  - On upd_valid && upd_ready: last_sent←upd pattern and upd_valid←0. Comparison resumes the next cycle, so a back-to-back update is issued ≥2 cycles after acceptance. The minimum spacing between transfers is 2 cycles.
  - Intermediate live patterns that are already restored by the time comparison runs produce no transfer.
- No update is issued after reset until live becomes non-zero, because last_sent resets to 0.

Decomposition:
- Shared package (led_pkg):
  - LED_CNT=10
  - the {ledg, ledr} pattern struct/typedef
  - the default TICK_DIV/HOLD_TICKS constants, shared with the LED register stage
- One sub-module: led_hold_counter (CNT_W counter with load/dec/saturate and a lit output), instantiated 20 times through generate.
- Prescaler, heartbeat and handshake logic stay in the top module.

Test Plan:
- Common settings: TICK_DIV=4, HOLD_TICKS=3, HB_EN=0, upd_ready=1 unless stated.
1. Reset: hold rst 3 cycles, then apply act pulses during rst → all outputs 0 and no upd_valid. Release rst → tick_o first high at cycle 3, period 4.
2. Single pulse: act_r[2] at cycle 10.
   - upd_valid at 12 with ledr=0x004, ledg=0.
   - LED turns off within 8–12 cycles.
   - A second update follows with ledr=0x000.
3. Retrigger and collision: pulse act_g[0] on a tick cycle, then again 5 cycles later → the reload wins each time, the counter reads 3 after each pulse, and there is exactly one on-update and one off-update.
4. Backpressure: hold upd_ready=0 for 20 cycles while act_g toggles various bits.
   - upd_valid and the data stay frozen at the first pattern.
   - After ready rises, the first transfer is accepted and the next update carries the current live pattern.
5. Heartbeat: HB_EN=1, HB_TICKS=2 → upd_ledg[9] alternates every 8 cycles. Pulsing act_g[9] has no effect.
6. All channels: pulse all 20 inputs in the same cycle → one update with ledg=ledr=0x3FF, then one update with both at 0x000.

Source files
------------

// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pkg
// Description : Shared constants and types for the LED activity stretcher and
//               the downstream LED register stage.
// Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

    // LEDs per colour bank
    localparam int LED_CNT = 10;

    // Green channel that carries the heartbeat when it is enabled
    localparam int HB_CH = LED_CNT - 1;

    // Default timing shared with the LED register stage
    localparam int DEF_TICK_DIV   = 50000;
    localparam int DEF_HOLD_TICKS = 100;

    // Combined LED pattern carried by one update transfer
    typedef struct packed {
        logic [LED_CNT-1:0] ledg;
        logic [LED_CNT-1:0] ledr;
    } led_pattern_t;

    // Update-port handshake state
    typedef enum logic [0:0] {
        HS_IDLE = 1'b0,
        HS_PEND = 1'b1
    } hs_state_t;

endpackage : led_pkg
`default_nettype wire

// File: rtl/led_hold_counter.sv
`default_nettype none
// ============================================================================
// Module      : led_hold_counter
// Description : Per-LED hold counter. An activity pulse reloads the full hold
//               time; each stretch tick counts it down to zero, where it
//               stays. The LED is lit while the count is non-zero.
// Revision    : 1.0 - initial release
// ============================================================================
module led_hold_counter
    import led_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int HOLD_TICKS = DEF_HOLD_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic lit
);

    localparam logic [CNT_W-1:0] HOLD_VAL = CNT_W'(HOLD_TICKS);

    logic [CNT_W-1:0] r_cnt;

    // Reload takes priority over a decrement landing in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= HOLD_VAL;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign lit = (r_cnt != '0);

endmodule : led_hold_counter
`default_nettype wire

// File: rtl/led_activity_stretcher.sv
`default_nettype none
// ============================================================================
// Module      : led_activity_stretcher
// Description : Stretches single-cycle activity pulses on 10 green and 10 red
//               channels into visible LED on-times, optionally replaces green
//               channel 9 with a heartbeat, and publishes pattern changes to
//               the LED register stage over a valid/ready update port.
// Revision    : 1.0 - initial release
// ============================================================================
module led_activity_stretcher
    import led_pkg::*;
#(
    parameter int TICK_DIV   = DEF_TICK_DIV,
    parameter int HOLD_TICKS = DEF_HOLD_TICKS,
    parameter int CNT_W      = 8,
    parameter int HB_EN      = 1,
    parameter int HB_TICKS   = 250
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LED_CNT-1:0] act_g,
    input  logic [LED_CNT-1:0] act_r,
    output logic               upd_valid,
    input  logic               upd_ready,
    output logic [LED_CNT-1:0] upd_ledg,
    output logic [LED_CNT-1:0] upd_ledr,
    output logic               tick_o
);

    // ------------------------------------------------------------------
    // Prescaler: one-cycle tick every TICK_DIV clocks
    // ------------------------------------------------------------------
    localparam int                PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] r_pre;
    logic             w_tick;

    assign w_tick = (r_pre == PRE_LAST);

    // Free-running prescaler that wraps on the tick cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Heartbeat: phase toggles every HB_TICKS ticks
    // ------------------------------------------------------------------
    localparam int               HB_W    = (HB_TICKS > 1) ? $clog2(HB_TICKS) : 1;
    localparam logic [HB_W-1:0]  HB_LAST = HB_W'(HB_TICKS - 1);

    logic [HB_W-1:0] r_hb_cnt;
    logic            r_hb_phase;
    logic            w_hb_wrap;

    assign w_hb_wrap = w_tick && (r_hb_cnt == HB_LAST);

    // Tick counter and phase bit; the phase flips on the wrapping tick
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hb_cnt   <= '0;
            r_hb_phase <= 1'b0;
        end else if (w_hb_wrap) begin
            r_hb_cnt   <= '0;
            r_hb_phase <= ~r_hb_phase;
        end else if (w_tick) begin
            r_hb_cnt   <= r_hb_cnt + HB_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Per-channel hold counters
    // ------------------------------------------------------------------
    logic [LED_CNT-1:0] w_load_g;
    logic [LED_CNT-1:0] w_lit_g;
    logic [LED_CNT-1:0] w_lit_r;
    logic [LED_CNT-1:0] w_live_g;

    // The heartbeat channel ignores its activity input when enabled
    always_comb begin
        w_load_g = act_g;
        if (HB_EN != 0) begin
            w_load_g[HB_CH] = 1'b0;
        end
    end

    for (genvar i = 0; i < LED_CNT; i++) begin : g_chan
        led_hold_counter #(
            .CNT_W      (CNT_W),
            .HOLD_TICKS (HOLD_TICKS)
        ) u_hold_g (
            .clk  (clk),
            .rst  (rst),
            .load (w_load_g[i]),
            .dec  (w_tick),
            .lit  (w_lit_g[i])
        );

        led_hold_counter #(
            .CNT_W      (CNT_W),
            .HOLD_TICKS (HOLD_TICKS)
        ) u_hold_r (
            .clk  (clk),
            .rst  (rst),
            .load (act_r[i]),
            .dec  (w_tick),
            .lit  (w_lit_r[i])
        );
    end

    // Live green pattern, with the heartbeat substituted on its channel
    always_comb begin
        w_live_g = w_lit_g;
        if (HB_EN != 0) begin
            w_live_g[HB_CH] = r_hb_phase;
        end
    end

    led_pattern_t w_live;
    assign w_live.ledg = w_live_g;
    assign w_live.ledr = w_lit_r;

    // ------------------------------------------------------------------
    // Update handshake
    // ------------------------------------------------------------------
    hs_state_t    r_state;
    hs_state_t    w_state_nxt;
    logic         w_capture;
    logic         w_accept;
    led_pattern_t r_upd;
    led_pattern_t r_last;

    // Next-state: capture a changed pattern when idle, retire it on ready
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            HS_IDLE: begin
                if (w_live != r_last) begin
                    w_capture   = 1'b1;
                    w_state_nxt = HS_PEND;
                end
            end
            HS_PEND: begin
                if (upd_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = HS_IDLE;
                end
            end
            default: begin
                w_state_nxt = HS_IDLE;
            end
        endcase
    end

    // Handshake state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= HS_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pending pattern is frozen while it waits; last_sent updates on accept
    always_ff @(posedge clk) begin
        if (rst) begin
            r_upd  <= '0;
            r_last <= '0;
        end else begin
            if (w_capture) begin
                r_upd <= w_live;
            end
            if (w_accept) begin
                r_last <= r_upd;
            end
        end
    end

    assign upd_valid = (r_state == HS_PEND);
    assign upd_ledg  = r_upd.ledg;
    assign upd_ledr  = r_upd.ledr;
    assign tick_o    = w_tick;

endmodule : led_activity_stretcher
`default_nettype wire

// File: tb/tb_led_activity_stretcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_activity_stretcher
// Description : Directed self-checking bench for led_activity_stretcher with
//               TICK_DIV=4, HOLD_TICKS=3. A second instance runs the
//               heartbeat with HB_TICKS=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_activity_stretcher;

    logic       clk;
    logic       rst;
    logic [9:0] act_g;
    logic [9:0] act_r;
    logic       upd_valid;
    logic       upd_ready;
    logic [9:0] upd_ledg;
    logic [9:0] upd_ledr;
    logic       tick_o;

    logic [9:0] hb_act_g;
    logic [9:0] hb_act_r;
    logic       hb_valid;
    logic       hb_ready;
    logic [9:0] hb_ledg;
    logic [9:0] hb_ledr;
    logic       hb_tick;

    int n_assert = 0;
    int n_fail   = 0;
    int n_xfer   = 0;
    int cyc      = 0;
    int xfer0    = 0;

    led_activity_stretcher #(
        .TICK_DIV   (4),
        .HOLD_TICKS (3),
        .CNT_W      (8),
        .HB_EN      (0),
        .HB_TICKS   (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .act_g     (act_g),
        .act_r     (act_r),
        .upd_valid (upd_valid),
        .upd_ready (upd_ready),
        .upd_ledg  (upd_ledg),
        .upd_ledr  (upd_ledr),
        .tick_o    (tick_o)
    );

    led_activity_stretcher #(
        .TICK_DIV   (4),
        .HOLD_TICKS (3),
        .CNT_W      (8),
        .HB_EN      (1),
        .HB_TICKS   (2)
    ) dut_hb (
        .clk       (clk),
        .rst       (rst),
        .act_g     (hb_act_g),
        .act_r     (hb_act_r),
        .upd_valid (hb_valid),
        .upd_ready (hb_ready),
        .upd_ledg  (hb_ledg),
        .upd_ledr  (hb_ledr),
        .tick_o    (hb_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count accepted transfers on the main instance
    always @(negedge clk) begin
        if (!rst && upd_valid && upd_ready) n_xfer++;
    end

    // Safety net against a hung run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, required finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_main"}, 32'({upd_valid, tick_o, upd_ledg, upd_ledr}), 32'd0);
        check({tag, "_hb"},   32'({hb_valid, hb_tick, hb_ledg, hb_ledr}),    32'd0);
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (!upd_valid && n < budget) begin
            step();
            n++;
        end
    endtask

    initial begin
        rst       = 1'b1;
        act_g     = '0;
        act_r     = '0;
        upd_ready = 1'b1;
        hb_act_g  = '0;
        hb_act_r  = '0;
        hb_ready  = 1'b1;

        // ---------------- Reset with activity applied ----------------
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check_zero("reset_hold");
            act_g    = 10'h3FF;
            act_r    = 10'h3FF;
            hb_act_g = 10'h3FF;
            hb_act_r = 10'h3FF;
            step();
        end
        check_zero("reset_act");
        rst      = 1'b0;
        act_g    = '0;
        act_r    = '0;
        hb_act_g = '0;
        hb_act_r = '0;
        cyc      = 0;

        // Tick first at cycle 3, then every 4 cycles; nothing lit yet
        while (cyc < 10) begin
            check("tick_phase", 32'(tick_o), 32'((cyc % 4) == 3));
            check("idle_valid", 32'(upd_valid), 32'd0);
            step();
        end

        // ---------------- Single red pulse at cycle 10 ----------------
        act_r = 10'h004;
        step();
        act_r = '0;
        check("pulse_n1_valid", 32'(upd_valid), 32'd0);
        step();
        check("pulse_on_valid", 32'(upd_valid), 32'd1);
        check("pulse_on_data", 32'({upd_ledg, upd_ledr}), 32'({10'h000, 10'h004}));
        step();
        check("pulse_accepted", 32'(upd_valid), 32'd0);
        wait_valid(20);
        check("pulse_off_cycle", 32'(cyc), 32'd21);
        check("pulse_off_data", 32'({upd_ledg, upd_ledr}), 32'd0);
        step();

        // ---------------- Retrigger / reload-vs-tick collision ----------------
        while (cyc < 27) step();
        xfer0 = n_xfer;
        act_g = 10'h001;                       // cycle 27 is a tick cycle
        step();
        act_g = '0;
        step();
        check("retrig_on_valid", 32'(upd_valid), 32'd1);
        check("retrig_on_data", 32'({upd_ledg, upd_ledr}), 32'({10'h001, 10'h000}));
        while (cyc < 31) step();
        act_g = 10'h001;                       // tick cycle with count non-zero
        step();
        act_g = '0;
        step();
        check("retrig_no_update", 32'(upd_valid), 32'd0);
        wait_valid(30);
        check("retrig_off_cycle", 32'(cyc), 32'd45);
        check("retrig_off_data", 32'({upd_ledg, upd_ledr}), 32'd0);
        step();
        check("retrig_xfers", 32'(n_xfer - xfer0), 32'd2);

        // ---------------- Backpressure ----------------
        while (cyc < 48) step();
        xfer0     = n_xfer;
        upd_ready = 1'b0;
        act_g     = 10'h003;
        step();
        act_g = '0;
        step();
        check("bp_first_valid", 32'(upd_valid), 32'd1);
        check("bp_first_data", 32'({upd_ledg, upd_ledr}), 32'({10'h003, 10'h000}));
        while (cyc < 68) begin
            check("bp_frozen", 32'({upd_valid, upd_ledg, upd_ledr}), 32'({1'b1, 10'h003, 10'h000}));
            act_g = (cyc == 52) ? 10'h010 :
                    (cyc == 56) ? 10'h100 :
                    (cyc == 66) ? 10'h020 : 10'h000;
            step();
        end
        act_g     = '0;
        upd_ready = 1'b1;
        check("bp_release_data", 32'({upd_valid, upd_ledg}), 32'({1'b1, 10'h003}));
        step();
        check("bp_gap", 32'(upd_valid), 32'd0);
        step();
        check("bp_next_valid", 32'(upd_valid), 32'd1);
        check("bp_next_data", 32'({upd_ledg, upd_ledr}), 32'({10'h020, 10'h000}));
        step();
        wait_valid(20);
        check("bp_off_cycle", 32'(cyc), 32'd77);
        check("bp_off_data", 32'({upd_ledg, upd_ledr}), 32'd0);
        step();
        check("bp_xfers", 32'(n_xfer - xfer0), 32'd3);

        // ---------------- All 20 channels at once ----------------
        while (cyc < 80) step();
        xfer0 = n_xfer;
        act_g = 10'h3FF;
        act_r = 10'h3FF;
        step();
        act_g = '0;
        act_r = '0;
        step();
        check("all_on_valid", 32'(upd_valid), 32'd1);
        check("all_on_data", 32'({upd_ledg, upd_ledr}), 32'({10'h3FF, 10'h3FF}));
        step();
        wait_valid(20);
        check("all_off_cycle", 32'(cyc), 32'd93);
        check("all_off_data", 32'({upd_ledg, upd_ledr}), 32'd0);
        step();
        check("all_xfers", 32'(n_xfer - xfer0), 32'd2);

        // ---------------- Heartbeat instance ----------------
        // Phase flips every 8 cycles; updates appear at 9, 17, 25, ...
        while (cyc < 126) begin
            if (((cyc - 9) % 8) == 0) begin
                check("hb_valid", 32'(hb_valid), 32'd1);
                check("hb_data", 32'({hb_ledg, hb_ledr}),
                      32'({((((cyc - 9) / 8) % 2) == 0) ? 10'h200 : 10'h000, 10'h000}));
            end else begin
                check("hb_idle", 32'(hb_valid), 32'd0);
            end
            hb_act_g = ((cyc == 100) || (cyc == 110)) ? 10'h200 : 10'h000;
            step();
        end
        hb_act_g = '0;

        // ---------------- Reset drops a pending update ----------------
        upd_ready = 1'b0;
        act_g     = 10'h001;
        step();
        act_g = '0;
        step();
        check("rst_pending_valid", 32'({upd_valid, upd_ledg}), 32'({1'b1, 10'h001}));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_zero("rst_mid");
        upd_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("rst_no_replay", 32'(upd_valid), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_led_activity_stretcher
`default_nettype wire
